// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and forwarding controller for a 5-stage RV32I pipeline. It decodes
// the instruction in IF/ID and keeps a shadow copy of the register usage of
// the EX, MEM and WB stages. From that state it produces the pipeline write
// enables, the ID/EX bubble, the IF/ID flush and the EX operand forwarding
// selects. Saturating counters record load-use stall cycles and flush cycles.
//
// Ports
//   clk               in   pipeline clock, all state changes on rising edge
//   reset             in   synchronous, active-high
//   if_id_instruction in   [31:0] instruction held in IF/ID
//   if_id_valid       in   IF/ID holds a real instruction (0 = bubble)
//   branch_taken_ex   in   branch/jump resolved taken in EX this cycle
//   pc_write          out  PC load enable
//   if_id_write       out  IF/ID load enable
//   if_id_flush       out  turn IF/ID into a NOP on the next edge
//   id_ex_bubble      out  load a NOP into ID/EX on the next edge
//   forward_a         out  [1:0] EX operand A: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   forward_b         out  [1:0] EX operand B, same encoding
//   stall_count       out  [CNT_W-1:0] saturating load-use stall cycle count
//   flush_count       out  [CNT_W-1:0] saturating flush cycle count
//
// Handshake: there is no valid/ready pair; every control output is a
// same-cycle combinational function of the inputs and the shadow state.
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      if_id_instruction,
    input  logic             if_id_valid,
    input  logic             branch_taken_ex,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       writes_rd;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs1;
        logic       uses_rs2;
    } stage_t;

    stage_t id_dec;
    stage_t ex_q, ex_d;
    stage_t mem_q, mem_d;
    stage_t wb_q, wb_d;

    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    logic load_use;
    logic stall_event;
    logic flush_event;
    logic bubble_int;
    logic [1:0] fwd_a_raw;
    logic [1:0] fwd_b_raw;

    // ---------------- ID decode ----------------
    always_comb begin
        logic known;
        logic u1;
        logic u2;
        logic wr;
        known  = 1'b1;
        u1     = 1'b0;
        u2     = 1'b0;
        wr     = 1'b0;
        id_dec = '0;
        unique case (if_id_instruction[6:0])
            OP_R:      begin u1 = 1'b1; u2 = 1'b1; wr = 1'b1; end
            OP_I_ALU:  begin u1 = 1'b1; wr = 1'b1; end
            OP_LOAD:   begin u1 = 1'b1; wr = 1'b1; end
            OP_STORE:  begin u1 = 1'b1; u2 = 1'b1; end
            OP_BRANCH: begin u1 = 1'b1; u2 = 1'b1; end
            OP_JALR:   begin u1 = 1'b1; wr = 1'b1; end
            OP_JAL:    wr = 1'b1;
            OP_LUI:    wr = 1'b1;
            OP_AUIPC:  wr = 1'b1;
            default:   known = 1'b0;
        endcase
        if (if_id_valid && known) begin
            id_dec.valid     = 1'b1;
            id_dec.rd        = if_id_instruction[11:7];
            id_dec.rs1       = if_id_instruction[19:15];
            id_dec.rs2       = if_id_instruction[24:20];
            // x0 is hard-wired: reading or writing it never creates a dependency
            id_dec.writes_rd = wr && (if_id_instruction[11:7] != 5'd0);
            id_dec.uses_rs1  = u1 && (if_id_instruction[19:15] != 5'd0);
            id_dec.uses_rs2  = u2 && (if_id_instruction[24:20] != 5'd0);
            id_dec.is_load   = (if_id_instruction[6:0] == OP_LOAD);
        end
    end

    // ---------------- hazard detection ----------------
    always_comb begin
        load_use = ex_q.is_load && (ex_q.rd != 5'd0) &&
                   ((id_dec.uses_rs1 && (id_dec.rs1 == ex_q.rd)) ||
                    (id_dec.uses_rs2 && (id_dec.rs2 == ex_q.rd)));
        // a taken branch squashes the dependent instruction, so its stall is moot
        stall_event = !reset && load_use && !branch_taken_ex;
        flush_event = !reset && branch_taken_ex;
        bubble_int  = stall_event || flush_event;
    end

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (flush_event) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (stall_event) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // ---------------- forwarding ----------------
    always_comb begin
        fwd_a_raw = 2'b00;
        fwd_b_raw = 2'b00;
        if (mem_q.writes_rd && (mem_q.rd != 5'd0) && ex_q.uses_rs1 && (mem_q.rd == ex_q.rs1))
            fwd_a_raw = 2'b10;
        else if (wb_q.writes_rd && (wb_q.rd != 5'd0) && ex_q.uses_rs1 && (wb_q.rd == ex_q.rs1))
            fwd_a_raw = 2'b01;
        if (mem_q.writes_rd && (mem_q.rd != 5'd0) && ex_q.uses_rs2 && (mem_q.rd == ex_q.rs2))
            fwd_b_raw = 2'b10;
        else if (wb_q.writes_rd && (wb_q.rd != 5'd0) && ex_q.uses_rs2 && (wb_q.rd == ex_q.rs2))
            fwd_b_raw = 2'b01;
        forward_a = reset ? 2'b00 : fwd_a_raw;
        forward_b = reset ? 2'b00 : fwd_b_raw;
    end

    // ---------------- next state ----------------
    always_comb begin
        wb_d  = mem_q;
        mem_d = ex_q;
        ex_d  = bubble_int ? '0 : id_dec;

        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (stall_event && (stall_count_q != {CNT_W{1'b1}}))
            stall_count_d = stall_count_q + CNT_W'(1);
        if (flush_event && (flush_count_q != {CNT_W{1'b1}}))
            flush_count_d = flush_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

    // Fields carried for observability but not consumed by any decision.
    logic unused_bits;
    assign unused_bits = ^{if_id_instruction[31:25], if_id_instruction[14:12],
                           ex_q.valid, ex_q.writes_rd, mem_q, wb_q};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [31:0] if_id_instruction = 32'h0000_0013;
    logic        if_id_valid = 1'b1;
    logic        branch_taken_ex = 1'b0;

    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic [1:0]  forward_a, forward_b;
    logic [15:0] stall_count, flush_count;

    logic        pc_write2, if_id_write2, if_id_flush2, id_ex_bubble2;
    logic [1:0]  forward_a2, forward_b2;
    logic [1:0]  stall_count2, flush_count2;

    pipeline_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid),
        .branch_taken_ex(branch_taken_ex),
        .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
        .forward_a(forward_a), .forward_b(forward_b),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_hazard_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid),
        .branch_taken_ex(branch_taken_ex),
        .pc_write(pc_write2), .if_id_write(if_id_write2),
        .if_id_flush(if_id_flush2), .id_ex_bubble(id_ex_bubble2),
        .forward_a(forward_a2), .forward_b(forward_b2),
        .stall_count(stall_count2), .flush_count(flush_count2)
    );

    // ---------------- scoreboard counters ----------------
    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Each in-flight instruction is summarised as: register it writes (0 = none),
    // registers it reads (0 = none) and whether it is a load. Index 0 = EX,
    // 1 = MEM, 2 = WB.
    int m_rd[3], m_s1[3], m_s2[3];
    bit m_ld[3];
    int m_stall = 0, m_flush = 0;

    function automatic void decode(input logic [31:0] ins, input logic v,
                                   output int rd, output int s1, output int s2, output bit ld);
        logic [6:0] op;
        bit u1, u2, w;
        op = ins[6:0];
        u1 = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
        u2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        w  = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111, 7'b1100111,
                        7'b0110111, 7'b0010111};
        rd = (v && w)  ? int'(ins[11:7])  : 0;
        s1 = (v && u1) ? int'(ins[19:15]) : 0;
        s2 = (v && u2) ? int'(ins[24:20]) : 0;
        ld = v && (op == 7'b0000011);
    endfunction

    // Source select for one operand register of the instruction in EX.
    function automatic int fwd_sel(input int src);
        if (src == 0)         return 0;
        if (m_rd[1] == src)   return 2;
        if (m_rd[2] == src)   return 1;
        return 0;
    endfunction

    function automatic bit model_hazard();
        int rd, s1, s2;
        bit ld;
        decode(if_id_instruction, if_id_valid, rd, s1, s2, ld);
        return m_ld[0] && (m_rd[0] != 0) && ((s1 == m_rd[0]) || (s2 == m_rd[0]));
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk) begin
        int rd, s1, s2;
        bit ld, hz, br;
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                m_rd[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_ld[i] = 0;
            end
            m_stall = 0;
            m_flush = 0;
        end else begin
            br = branch_taken_ex;
            hz = model_hazard();
            decode(if_id_instruction, if_id_valid, rd, s1, s2, ld);
            for (int i = 2; i > 0; i--) begin
                m_rd[i] = m_rd[i-1]; m_s1[i] = m_s1[i-1];
                m_s2[i] = m_s2[i-1]; m_ld[i] = m_ld[i-1];
            end
            if (br || hz) begin
                m_rd[0] = 0; m_s1[0] = 0; m_s2[0] = 0; m_ld[0] = 0;
            end else begin
                m_rd[0] = rd; m_s1[0] = s1; m_s2[0] = s2; m_ld[0] = ld;
            end
            if (hz && !br) m_stall++;
            if (br) m_flush++;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bit stall, br, hz;
        int fa, fb;
        if (chk_en) begin
            if (reset) begin
                stall = 0; br = 0; hz = 0; fa = 0; fb = 0;
            end else begin
                br = branch_taken_ex;
                hz = model_hazard();
                stall = hz && !br;
                fa = fwd_sel(m_s1[0]);
                fb = fwd_sel(m_s2[0]);
            end
            chk("pc_write",      {31'd0, pc_write},     32'(!stall));
            chk("if_id_write",   {31'd0, if_id_write},  32'(!stall));
            chk("if_id_flush",   {31'd0, if_id_flush},  32'(br));
            chk("id_ex_bubble",  {31'd0, id_ex_bubble}, 32'(br || stall));
            chk("forward_a",     {30'd0, forward_a},    32'(fa));
            chk("forward_b",     {30'd0, forward_b},    32'(fb));
            chk("stall_count",   {16'd0, stall_count},  32'(sat(m_stall, 65535)));
            chk("flush_count",   {16'd0, flush_count},  32'(sat(m_flush, 65535)));
            chk("pc_write_w2",   {31'd0, pc_write2},    32'(!stall));
            chk("forward_a_w2",  {30'd0, forward_a2},   32'(fa));
            chk("stall_count_w2",{30'd0, stall_count2}, 32'(sat(m_stall, 3)));
            chk("flush_count_w2",{30'd0, flush_count2}, 32'(sat(m_flush, 3)));
        end
    end

    // ---------------- driver tasks ----------------
    localparam logic [31:0] NOP = 32'h0000_0013;

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    // Apply one cycle of inputs just after the rising edge; return shortly
    // after the following falling edge so outputs can be sampled.
    task automatic cyc(input logic [31:0] ins, input logic v, input logic br, input logic rst);
        @(posedge clk);
        #1;
        if_id_instruction = ins;
        if_id_valid       = v;
        branch_taken_ex   = br;
        reset             = rst;
        @(negedge clk);
        #1;
    endtask

    logic [31:0] i_lw5, i_add6, i_add3, i_sub4, i_or7, i_lw0, i_add1;
    logic [6:0]  ops [10];

    initial begin
        i_lw5  = lw(5'd5, 5'd1);
        i_add6 = rtype(7'd0, 5'd2, 5'd5, 3'b000, 5'd6);
        i_add3 = rtype(7'd0, 5'd2, 5'd1, 3'b000, 5'd3);
        i_sub4 = rtype(7'b0100000, 5'd3, 5'd3, 3'b000, 5'd4);
        i_or7  = rtype(7'd0, 5'd0, 5'd3, 3'b110, 5'd7);
        i_lw0  = lw(5'd0, 5'd1);
        i_add1 = rtype(7'd0, 5'd0, 5'd0, 3'b000, 5'd1);
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1100111, 7'b1101111, 7'b0110111, 7'b0010111, 7'b1110011};

        @(posedge clk);
        #1 chk_en = 1'b1;

        // independent ADDs
        cyc(NOP, 1, 0, 1);
        chk("rst_pc_write", {31'd0, pc_write}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            cyc(rtype(7'd0, 5'(21 + i), 5'(20 + i), 3'b000, 5'(10 + i)), 1, 0, 0);
            chk("indep_pc_write", {31'd0, pc_write}, 32'd1);
            chk("indep_fwd", {28'd0, forward_a, forward_b}, 32'd0);
        end
        cyc(NOP, 1, 0, 0);
        chk("indep_stall_count", {16'd0, stall_count}, 32'd0);

        // load-use: LW x5 ; ADD x6,x5,x2
        cyc(NOP, 1, 0, 1);
        cyc(i_lw5, 1, 0, 0);
        cyc(i_add6, 1, 0, 0);
        chk("lu_pc_write", {31'd0, pc_write}, 32'd0);
        chk("lu_if_id_write", {31'd0, if_id_write}, 32'd0);
        chk("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
        cyc(i_add6, 1, 0, 0);
        chk("lu_release", {31'd0, pc_write}, 32'd1);
        chk("lu_stall_count", {16'd0, stall_count}, 32'd1);
        cyc(NOP, 1, 0, 0);
        chk("lu_forward_a", {30'd0, forward_a}, 32'd1);

        // ADD x3 ; SUB x4,x3,x3 ; OR x7,x3,x0
        cyc(NOP, 1, 0, 1);
        cyc(i_add3, 1, 0, 0);
        cyc(i_sub4, 1, 0, 0);
        cyc(i_or7, 1, 0, 0);
        chk("sub_forward_a", {30'd0, forward_a}, 32'd2);
        chk("sub_forward_b", {30'd0, forward_b}, 32'd2);
        cyc(NOP, 1, 0, 0);
        chk("or_forward_a", {30'd0, forward_a}, 32'd1);
        chk("or_forward_b", {30'd0, forward_b}, 32'd0);

        // stall coinciding with flush
        cyc(NOP, 1, 0, 1);
        cyc(i_lw5, 1, 0, 0);
        cyc(i_add6, 1, 1, 0);
        chk("fl_flush", {31'd0, if_id_flush}, 32'd1);
        chk("fl_bubble", {31'd0, id_ex_bubble}, 32'd1);
        chk("fl_pc_write", {31'd0, pc_write}, 32'd1);
        cyc(NOP, 1, 0, 0);
        chk("fl_stall_count", {16'd0, stall_count}, 32'd0);
        chk("fl_flush_count", {16'd0, flush_count}, 32'd1);

        // x0 dependency and invalid IF/ID
        cyc(NOP, 1, 0, 1);
        cyc(i_lw0, 1, 0, 0);
        cyc(i_add1, 1, 0, 0);
        chk("x0_pc_write", {31'd0, pc_write}, 32'd1);
        cyc(NOP, 1, 0, 0);
        chk("x0_fwd", {28'd0, forward_a, forward_b}, 32'd0);
        cyc(i_lw5, 1, 0, 0);
        cyc(i_add6, 0, 0, 0);
        chk("inv_pc_write", {31'd0, pc_write}, 32'd1);
        chk("inv_bubble", {31'd0, id_ex_bubble}, 32'd0);

        // saturation, then reset mid-stall
        cyc(NOP, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(i_lw5, 1, 0, 0);
            cyc(i_add6, 1, 0, 0);
            cyc(i_add6, 1, 0, 0);
        end
        chk("sat_stall_w2", {30'd0, stall_count2}, 32'd3);
        chk("sat_stall_w16", {16'd0, stall_count}, 32'd5);
        cyc(i_lw5, 1, 0, 0);
        cyc(i_add6, 1, 0, 1);
        chk("rst_mid_pc_write", {31'd0, pc_write}, 32'd1);
        chk("rst_mid_bubble", {31'd0, id_ex_bubble}, 32'd0);
        cyc(i_add6, 1, 0, 0);
        chk("post_rst_pc_write", {31'd0, pc_write}, 32'd1);
        chk("post_rst_stall", {30'd0, stall_count2}, 32'd0);
        chk("post_rst_flush", {16'd0, flush_count}, 32'd0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[6:0]   = ops[$urandom_range(0, 9)];
            ins[11:7]  = 5'($urandom_range(0, 5));
            ins[19:15] = 5'($urandom_range(0, 5));
            ins[24:20] = 5'($urandom_range(0, 5));
            cyc(ins, $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 99) == 0);
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
